// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter with optional parity, 1 or 2 stop bits and CTS-gated frame start
module uart_tx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int CTS_EN       = 1
) (
  input  logic       clk25,
  input  logic       rst_,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       cts_,
  output logic       txd,
  output logic       drv_ena_,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  shreg;
  logic        sidx, par, run, cts_s1, cts_s2;
  logic        cts_ok, bit_end, last, accept;
  assign cts_ok   = (CTS_EN == 0) || !cts_s2;
  assign bit_end  = cnt == 16'd0;
  assign last     = state == STOP && bit_end && sidx == 1'(STOP_BITS - 1);
  assign tx_ready = run && cts_ok && (state == IDLE || last);
  assign accept   = tx_valid && tx_ready;
  always_ff @(posedge clk25) begin
    if (!rst_) begin
      state    <= IDLE;
      txd      <= 1'b1;
      busy     <= 1'b0;
      drv_ena_ <= 1'b1;
      cnt      <= 16'd0;
      idx      <= 3'd0;
      sidx     <= 1'b0;
      shreg    <= 8'd0;
      par      <= 1'b0;
      run      <= 1'b0;
      cts_s1   <= 1'b1;
      cts_s2   <= 1'b1;
    end else begin
      run    <= 1'b1;
      cts_s1 <= cts_;
      cts_s2 <= cts_s1;
      if (accept) begin
        state    <= START;
        txd      <= 1'b0;
        busy     <= 1'b1;
        drv_ena_ <= 1'b0;
        cnt      <= 16'(CLKS_PER_BIT - 1);
        idx      <= 3'd0;
        sidx     <= 1'b0;
        shreg    <= tx_data;
        par      <= ^tx_data ^ 1'(PARITY_ODD);
      end else if (state != IDLE) begin
        cnt <= bit_end ? 16'(CLKS_PER_BIT - 1) : cnt - 16'd1;
        if (bit_end)
          case (state)
            START: begin
              state <= DATA;
              txd   <= shreg[0];
            end
            DATA: begin
              idx <= idx + 3'd1;
              if (idx == 3'd7) begin
                state <= (PARITY_EN != 0) ? PARITY : STOP;
                txd   <= (PARITY_EN != 0) ? par : 1'b1;
              end else
                txd <= shreg[idx + 3'd1];
            end
            PARITY: begin
              state <= STOP;
              txd   <= 1'b1;
            end
            STOP: begin
              if (last) begin
                state    <= IDLE;
                busy     <= 1'b0;
                drv_ena_ <= 1'b1;
              end else
                sidx <= 1'b1;
            end
            default: state <= IDLE;
          endcase
      end
    end
  end
endmodule
